// File: rtl/commands_pkg.sv
//------------------------------------------------------------------------------
// Module : commands (package)
// Brief  : Bus command encoding shared by the lock and the snoop responders.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package commands;

    typedef enum logic [1:0] {
        NONE               = 2'd0,
        BUS_READ           = 2'd1,
        BUS_READ_EXCLUSIVE = 2'd2,
        BUS_INVALIDATE     = 2'd3
    } command_t;

endpackage

`default_nettype wire

// File: rtl/states_pkg.sv
//------------------------------------------------------------------------------
// Module : states (package)
// Brief  : MSI line states and the snoop responder FSM encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package states;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } msiState_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_LINE = 2'd1;
    localparam logic [1:0] ST_UPDATE    = 2'd2;
    localparam logic [1:0] ST_ACK       = 2'd3;

endpackage

`default_nettype wire

// File: rtl/snoopy_controller_line_word_counter.sv
//------------------------------------------------------------------------------
// Module : line_word_counter
// Brief  : Word index within a cache line, with clear and last-word flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_word_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             lastWord
);

    logic [WIDTH-1:0] r_count;

    // Incrementing past the last word wraps naturally back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (increment) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign lastWord = &r_count;

endmodule

`default_nettype wire

// File: rtl/snoopy_controller.sv
//------------------------------------------------------------------------------
// Module : snoopy_controller
// Brief  : MSI snoop responder: flushes modified lines, updates state, acks bus.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snoopy_controller
    import commands::*;
    import states::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int OFFSET_WIDTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               commandIn,
    input  logic [ADDRESS_WIDTH-1:0] snoopAddress,
    input  logic                     snoopyHit,
    input  logic [1:0]               lineState,
    output logic [ADDRESS_WIDTH-1:0] cacheAddress,
    output logic                     cacheReadEnabled,
    input  logic [DATA_WIDTH-1:0]    cacheDataIn,
    input  logic                     cacheFunctionComplete,
    output logic                     stateWriteEnabled,
    output logic [1:0]               stateOut,
    output logic [DATA_WIDTH-1:0]    busDataOut,
    output logic                     busDataValid,
    output logic                     busOwned,
    output logic                     isInvalidated,
    output logic                     busDone,
    output logic                     protocolError
);

    localparam logic [ADDRESS_WIDTH-1:0] c_lineMask =
        {{(ADDRESS_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

    logic [1:0]               r_state;
    command_t                 r_command;
    logic [ADDRESS_WIDTH-1:0] r_snoopAddress;
    msiState_t                r_target;
    logic                     r_flushed;
    logic                     r_gap;
    logic                     r_protocolError;
    logic [DATA_WIDTH-1:0]    r_busDataOut;
    logic                     r_busDataValid;

    logic [1:0]               w_acceptState;
    msiState_t                w_acceptTarget;
    logic                     w_acceptFlush;
    logic                     w_acceptError;
    logic [OFFSET_WIDTH-1:0]  w_wordIndex;
    logic                     w_lastWord;
    logic                     w_wordDone;

    // Routing decision for a newly presented command, from hit and line state.
    always_comb begin
        w_acceptState  = ST_ACK;
        w_acceptTarget = INVALID;
        w_acceptFlush  = 1'b0;
        w_acceptError  = 1'b0;
        if (snoopyHit && lineState == SHARED && commandIn != BUS_READ) begin
            w_acceptState = ST_UPDATE;
        end else if (snoopyHit && lineState == MODIFIED) begin
            case (commandIn)
                BUS_READ: begin
                    w_acceptState  = ST_READ_LINE;
                    w_acceptTarget = SHARED;
                    w_acceptFlush  = 1'b1;
                end
                BUS_READ_EXCLUSIVE: begin
                    w_acceptState  = ST_READ_LINE;
                    w_acceptFlush  = 1'b1;
                end
                BUS_INVALIDATE: begin
                    w_acceptState  = ST_UPDATE;
                    w_acceptError  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_wordDone = (r_state == ST_READ_LINE) && !r_gap && cacheFunctionComplete;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_command       <= NONE;
            r_snoopAddress  <= '0;
            r_target        <= INVALID;
            r_flushed       <= 1'b0;
            r_gap           <= 1'b0;
            r_protocolError <= 1'b0;
            r_busDataOut    <= '0;
            r_busDataValid  <= 1'b0;
        end else begin
            r_busDataValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (commandIn != NONE) begin
                        r_command      <= command_t'(commandIn);
                        r_snoopAddress <= snoopAddress;
                        r_target       <= w_acceptTarget;
                        r_flushed      <= w_acceptFlush;
                        r_gap          <= 1'b0;
                        r_state        <= w_acceptState;
                        if (w_acceptError) begin
                            r_protocolError <= 1'b1;
                        end
                    end
                end
                ST_READ_LINE: begin
                    // The read request drops for one cycle after every word.
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (cacheFunctionComplete) begin
                        r_busDataOut   <= cacheDataIn;
                        r_busDataValid <= 1'b1;
                        r_gap          <= 1'b1;
                        if (w_lastWord) begin
                            r_state <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    if (commandIn == NONE) begin
                        r_state   <= ST_IDLE;
                        r_flushed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    line_word_counter #(
        .WIDTH (OFFSET_WIDTH)
    ) u_wordCounter (
        .clock     (clock),
        .reset     (reset),
        .increment (w_wordDone),
        .clear     (r_state == ST_IDLE),
        .count     (w_wordIndex),
        .lastWord  (w_lastWord)
    );

    assign cacheReadEnabled  = (r_state == ST_READ_LINE) && !r_gap;
    assign cacheAddress      = (r_state == ST_READ_LINE)
                             ? ((r_snoopAddress & c_lineMask) | ADDRESS_WIDTH'(w_wordIndex))
                             : '0;
    assign stateWriteEnabled = (r_state == ST_UPDATE);
    assign stateOut          = (r_state == ST_UPDATE) ? r_target : INVALID;
    assign busDataOut        = r_busDataOut;
    assign busDataValid      = r_busDataValid;
    assign busOwned          = r_flushed && (r_state != ST_IDLE);
    assign busDone           = (r_state == ST_ACK);
    assign isInvalidated     = (r_state == ST_ACK) &&
                               (r_command == BUS_READ_EXCLUSIVE || r_command == BUS_INVALIDATE);
    assign protocolError     = r_protocolError;

endmodule

`default_nettype wire

// File: tb/tb_snoopy_controller.sv
//------------------------------------------------------------------------------
// Module : tb_snoopy_controller
// Brief  : Directed and randomized bench for snoopy_controller with a cache model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_snoopy_controller;
    import commands::*;
    import states::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int OW    = 4;
    localparam int WORDS = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    commandIn;
    logic [AW-1:0] snoopAddress;
    logic          snoopyHit;
    logic [1:0]    lineState;
    logic [AW-1:0] cacheAddress;
    logic          cacheReadEnabled;
    logic [DW-1:0] cacheDataIn;
    logic          cacheFunctionComplete;
    logic          stateWriteEnabled;
    logic [1:0]    stateOut;
    logic [DW-1:0] busDataOut;
    logic          busDataValid;
    logic          busOwned;
    logic          isInvalidated;
    logic          busDone;
    logic          protocolError;

    int            nAssert = 0;
    int            nFail   = 0;
    logic [DW-1:0] mem [WORDS];
    int            cacheDelay = 0;
    bit            expError = 1'b0;

    snoopy_controller #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .OFFSET_WIDTH  (OW)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .commandIn             (commandIn),
        .snoopAddress          (snoopAddress),
        .snoopyHit             (snoopyHit),
        .lineState             (lineState),
        .cacheAddress          (cacheAddress),
        .cacheReadEnabled      (cacheReadEnabled),
        .cacheDataIn           (cacheDataIn),
        .cacheFunctionComplete (cacheFunctionComplete),
        .stateWriteEnabled     (stateWriteEnabled),
        .stateOut              (stateOut),
        .busDataOut            (busDataOut),
        .busDataValid          (busDataValid),
        .busOwned              (busOwned),
        .isInvalidated         (isInvalidated),
        .busDone               (busDone),
        .protocolError         (protocolError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {14'd0, cacheReadEnabled, stateWriteEnabled, stateOut, busDataValid,
                busOwned, isInvalidated, busDone, protocolError} | 32'(cacheAddress) | 32'(busDataOut);
    endfunction

    // Cache data-array model: completes a read cacheDelay cycles after the request is seen.
    initial begin
        int waitCnt;
        waitCnt = 0;
        cacheFunctionComplete = 1'b0;
        cacheDataIn = '0;
        forever begin
            @(negedge clock);
            if (cacheFunctionComplete) begin
                cacheFunctionComplete = 1'b0;
                waitCnt = 0;
            end else if (cacheReadEnabled) begin
                if (waitCnt >= cacheDelay) begin
                    cacheFunctionComplete = 1'b1;
                    cacheDataIn = mem[cacheAddress[OW-1:0]];
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    task automatic runTxn(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic hit,
                          input logic [1:0] st, input int delay, input string tag);
        bit            flush, write, inv, done;
        logic [1:0]    target;
        logic [AW-1:0] base;
        int            expLatency, cyc, idx, gaps, writes, readCycles;

        // Expected behaviour derived from the protocol rules.
        base   = addr & 16'hFFF0;
        flush  = hit && st == MODIFIED && (cmd == BUS_READ || cmd == BUS_READ_EXCLUSIVE);
        write  = hit && (st == MODIFIED || (st == SHARED && cmd != BUS_READ));
        target = (cmd == BUS_READ) ? SHARED : INVALID;
        inv    = (cmd == BUS_READ_EXCLUSIVE || cmd == BUS_INVALIDATE);
        if (hit && st == MODIFIED && cmd == BUS_INVALIDATE) expError = 1'b1;
        expLatency = 1 + (write ? 1 : 0) + (flush ? WORDS*(delay+1) + WORDS-1 : 0);

        for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom);
        cacheDelay = delay;

        @(negedge clock);
        commandIn    = cmd;
        snoopAddress = addr;
        snoopyHit    = hit;
        lineState    = st;

        cyc = 0; idx = 0; gaps = 0; writes = 0; readCycles = 0; done = 0;
        while (!done && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) commandIn = 2'($urandom_range(1, 3));
            if (busDataValid) begin
                check({tag, "/data"}, busDataOut, (idx < WORDS) ? mem[idx] : 16'hxxxx);
                idx++;
            end
            if (cacheReadEnabled) begin
                readCycles++;
                if (readCycles == 1 || busDataValid == 1'b0)
                    check({tag, "/addr"}, cacheAddress, base | AW'(idx));
            end else if (flush && !stateWriteEnabled && !busDone) begin
                gaps++;
            end
            if (stateWriteEnabled) begin
                writes++;
                check({tag, "/stateOut"}, stateOut, target);
                check({tag, "/ownedUpd"}, busOwned, flush);
            end
            if (busDone) done = 1;
        end

        check({tag, "/latency"}, cyc, expLatency);
        check({tag, "/words"}, idx, flush ? WORDS : 0);
        check({tag, "/readCycles"}, readCycles, flush ? WORDS*(delay+1) : 0);
        check({tag, "/gaps"}, gaps, flush ? WORDS-1 : 0);
        check({tag, "/writes"}, writes, write ? 1 : 0);
        check({tag, "/isInv"}, isInvalidated, inv);
        check({tag, "/protErr"}, protocolError, expError);

        @(negedge clock);
        check({tag, "/doneHeld"}, busDone, 1);
        commandIn = NONE;
        @(negedge clock);
        check({tag, "/idle"}, {busDone, isInvalidated, busOwned, stateWriteEnabled, cacheReadEnabled}, 0);
        check({tag, "/protErrIdle"}, protocolError, expError);
    endtask

    initial begin
        int valids;
        reset        = 1'b1;
        commandIn    = NONE;
        snoopAddress = '0;
        snoopyHit    = 1'b0;
        lineState    = INVALID;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        check("reset/outputs", allOutputs(), 0);
        reset = 1'b0;

        runTxn(BUS_READ,           16'h1230, 1'b0, MODIFIED, 0, "missRead");
        runTxn(BUS_INVALIDATE,     16'h4560, 1'b1, SHARED,   0, "sharedInv");
        runTxn(BUS_READ,           16'h7895, 1'b1, MODIFIED, 1, "flushRead");
        runTxn(BUS_READ_EXCLUSIVE, 16'hA5C3, 1'b1, MODIFIED, 3, "flushRdx");
        runTxn(BUS_INVALIDATE,     16'h2222, 1'b1, MODIFIED, 0, "invModified");
        runTxn(BUS_READ,           16'h3330, 1'b1, SHARED,   0, "afterError");

        for (int t = 0; t < 20; t++) begin
            runTxn(2'($urandom_range(1, 3)), AW'($urandom), 1'($urandom),
                   2'($urandom_range(0, 2)), $urandom_range(0, 3), "random");
        end

        // Asynchronous reset in the middle of a flush.
        for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom);
        cacheDelay = 1;
        @(negedge clock);
        commandIn    = BUS_READ;
        snoopAddress = 16'h5550;
        snoopyHit    = 1'b1;
        lineState    = MODIFIED;
        valids = 0;
        for (int c = 0; c < 200 && valids < 5; c++) begin
            @(negedge clock);
            if (busDataValid) valids++;
        end
        check("midReset/words", valids, 5);
        #2 reset = 1'b1;
        #1 check("midReset/outputs", allOutputs(), 0);
        commandIn = NONE;
        expError  = 1'b0;
        @(negedge clock);
        check("midReset/held", allOutputs(), 0);
        reset = 1'b0;

        runTxn(BUS_READ, 16'h5553, 1'b1, MODIFIED, 0, "postReset");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snoopy_controller.md
Name: snoopy_controller

Overview:
- Snoop-side responder of the invalidate-protocol (MSI) cache. Sits directly downstream of the concurrency lock and consumes its filtered bus command and snoop address.
- For each accepted bus command it reads the hit line's state, flushes a MODIFIED line word by word through the cache read port, and updates the line state.
- It returns the invalidation acknowledge and completion handshake to the bus.

Parameters:
ADDRESS_WIDTH, 16, byte/word address width of snoop address
DATA_WIDTH, 16, width of one cache word
OFFSET_WIDTH, 4, line offset bits; a line holds 2^OFFSET_WIDTH words

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
commandIn  in  2  bus command from lock: NONE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE (commands package)
snoopAddress  in  ADDRESS_WIDTH  snooped address
snoopyHit  in  1  tag match for snoopAddress
lineState  in  2  MSI state of hit line: INVALID, SHARED, MODIFIED
cacheAddress  out  ADDRESS_WIDTH  read address into cache data array
cacheReadEnabled  out  1  read request to cache data array
cacheDataIn  in  DATA_WIDTH  word returned by cache
cacheFunctionComplete  in  1  read completes this cycle
stateWriteEnabled  out  1  one-cycle strobe writing stateOut to hit line
stateOut  out  2  new line state
busDataOut  out  DATA_WIDTH  flushed word
busDataValid  out  1  one-cycle strobe per flushed word
busOwned  out  1  this cache supplies the line; memory must not respond
isInvalidated  out  1  invalidation acknowledged
busDone  out  1  command fully serviced
protocolError  out  1  sticky: BUS_INVALIDATE hit a MODIFIED line

Behaviour:
- Reset (async, any state): FSM to IDLE, word counter 0, latched command/address 0. All outputs 0, including protocolError.
- FSM states: IDLE, READ_LINE, UPDATE_STATE, ACK.
- IDLE: when commandIn != NONE, latch commandIn, line base address (snoopAddress with offset bits zeroed), snoopyHit and lineState. Choose next state from the latched values:
  - Miss, or state INVALID -> ACK.
  - BUS_READ and SHARED -> ACK.
  - BUS_READ and MODIFIED -> READ_LINE; stateOut target SHARED.
  - BUS_READ_EXCLUSIVE and MODIFIED -> READ_LINE; target INVALID.
  - BUS_READ_EXCLUSIVE or BUS_INVALIDATE, with SHARED -> UPDATE_STATE; target INVALID.
  - BUS_INVALIDATE and MODIFIED -> UPDATE_STATE; target INVALID; set protocolError. No flush.
- READ_LINE:
  - busOwned=1 throughout.
  - cacheAddress = base | counter. cacheReadEnabled held high until cacheFunctionComplete.
  - On complete: register cacheDataIn into busDataOut, pulse busDataValid next cycle, increment counter.
  - When the counter reaches 2^OFFSET_WIDTH-1 and completes, counter wraps to 0 and the FSM goes to UPDATE_STATE.
  - cacheReadEnabled drops for exactly one cycle between words.
- UPDATE_STATE: stateWriteEnabled=1 and stateOut=target for one cycle -> ACK. busOwned remains 1 if a flush occurred.
- ACK:
  - busDone=1.
  - isInvalidated=1 if the latched command is BUS_READ_EXCLUSIVE or BUS_INVALIDATE, whether or not the line was present.
  - Held until commandIn == NONE (4-phase handshake), then IDLE with all strobes/levels 0.
- commandIn changes during READ_LINE/UPDATE_STATE are ignored; the latched command governs.
- Latency:
  - Miss: busDone one cycle after acceptance.
  - Shared invalidate: busDone two cycles after acceptance.
  - Flush: 2^OFFSET_WIDTH reads, plus one cycle between words, plus 2 cycles.
- protocolError is cleared only by reset.

Decomposition:
- Command enum (NONE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE) stays in the existing commands package.
- New package states holds the MSI enum (INVALID, SHARED, MODIFIED) and the snoopy FSM state enum.
- One sub-module, line_word_counter: OFFSET_WIDTH-bit counter with increment, clear and last-word flag.

Test Plan:
- BUS_READ, snoopyHit=0 at 0x1230 -> busDone high 1 cycle later. No cache read, no state write, isInvalidated=0. Returns to IDLE after commandIn=NONE.
- BUS_INVALIDATE, hit SHARED at 0x4560 -> stateWriteEnabled pulse with stateOut=INVALID, then busDone=1 and isInvalidated=1. protocolError stays 0.
- BUS_READ, hit MODIFIED at 0x7895, cache completes each read next cycle -> cacheAddress sequences 0x7890..0x789F. 16 busDataValid pulses carry cacheDataIn. busOwned=1. stateOut=SHARED. busDone=1. isInvalidated=0.
- BUS_READ_EXCLUSIVE, hit MODIFIED with cacheFunctionComplete delayed 3 cycles per word -> cacheReadEnabled held until complete. Full 16-word flush, stateOut=INVALID, isInvalidated=1.
- BUS_INVALIDATE, hit MODIFIED -> no flush, stateOut=INVALID, protocolError=1 and still 1 after the next command.
- Reset asserted mid-flush at word 5 -> all outputs 0 immediately. Next BUS_READ flush restarts at word 0.
